// File: rtl/cache_pkg.sv
// Shared cache types and width helpers.
// Used by cache_wb_dm and its line store.
package cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  function automatic int tag_width(
    input int addr_w,
    input int sets,
    input int wpb
  );
    return addr_w - 2 - $clog2(sets) - $clog2(wpb);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/dirty/tag/data arrays for a direct-mapped cache.
// One index shared by lookup, word merge and block fill.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_W           = 4,
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IDX_W-1:0]           idx,
  input  logic [WORDS_PER_BLOCK-1:0] wr_mask,
  input  logic [BLOCK_W-1:0]         wr_block,
  input  logic                       set_dirty,
  input  logic                       clr_dirty,
  input  logic                       fill_en,
  input  logic [TAG_W-1:0]           fill_tag,
  input  logic [BLOCK_W-1:0]         fill_block,
  output logic                       rd_valid,
  output logic                       rd_dirty,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [BLOCK_W-1:0]         rd_block
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [BLOCK_W-1:0]  data_q [NUM_SETS];
  logic [BLOCK_W-1:0]  blk_d;
  logic                data_we;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_block = data_q[idx];
  assign data_we  = fill_en | (|wr_mask);

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_en) valid_d[idx] = 1'b1;
    if (set_dirty) dirty_d[idx] = 1'b1;
    if (clr_dirty || fill_en) dirty_d[idx] = 1'b0;
  end

  // Word 0 sits in the most significant slot of the block.
  always_comb begin
    blk_d = fill_en ? fill_block : data_q[idx];
    if (!fill_en) begin
      for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
        if (wr_mask[k]) begin
          blk_d[BLOCK_W-1-WORD_W*k -: WORD_W] =
            wr_block[BLOCK_W-1-WORD_W*k -: WORD_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[idx] <= blk_d;
    if (fill_en) tag_q[idx] <= fill_tag;
  end

endmodule

// File: rtl/cache_wb_dm.sv
// Direct-mapped write-back, write-allocate data cache.
// Optional counters: define CACHE_WB_DM_STATS_EN.
module cache_wb_dm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int NUM_SETS        = 4,
  parameter int WORDS_PER_BLOCK = 4,
  localparam int WOFF_W  = $clog2(WORDS_PER_BLOCK),
  localparam int IDX_W   = $clog2(NUM_SETS),
  localparam int TAG_W   = tag_width(ADDR_W, NUM_SETS, WORDS_PER_BLOCK),
  localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK,
  localparam int BADDR_W = TAG_W + IDX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic [WORD_W-1:0]  cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_hit,
  output logic               mem_req,
  output logic               mem_we,
  output logic [BADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ack
`ifdef CACHE_WB_DM_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt,
  output logic [31:0]        wb_cnt
`endif
);

  state_e state_q, state_d;
  logic [ADDR_W-3:0]    req_addr_q, req_addr_d;
  logic                 req_we_q, req_we_d;
  logic [WORD_W-1:0]    req_wdata_q, req_wdata_d;
  logic                 first_q, first_d;
  logic [WORD_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic                 cpu_ready_q, cpu_ready_d;
  logic                 cpu_hit_q, cpu_hit_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [BADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [WOFF_W-1:0]    req_woff;
  logic                 rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]     rd_tag;
  logic [BLOCK_W-1:0]   rd_block;
  logic [WORD_W-1:0]    rd_word;
  logic [WORDS_PER_BLOCK-1:0] wr_mask;
  logic                 set_dirty, clr_dirty, fill_en;
  logic                 unused_bits;

  assign unused_bits = ^cpu_addr[1:0];
  assign req_tag  = req_addr_q[ADDR_W-3 -: TAG_W];
  assign req_idx  = req_addr_q[WOFF_W +: IDX_W];
  assign req_woff = req_addr_q[WOFF_W-1:0];
  assign hit      = rd_valid && (rd_tag == req_tag);

  cache_line_store #(
    .NUM_SETS        (NUM_SETS),
    .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
    .TAG_W           (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .idx        (req_idx),
    .wr_mask    (wr_mask),
    .wr_block   ({WORDS_PER_BLOCK{req_wdata_q}}),
    .set_dirty  (set_dirty),
    .clr_dirty  (clr_dirty),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_block (mem_rdata),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_block   (rd_block)
  );

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
      if (req_woff == k[WOFF_W-1:0]) begin
        rd_word = rd_block[BLOCK_W-1-WORD_W*k -: WORD_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    first_d     = first_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_mask     = '0;
    set_dirty   = 1'b0;
    clr_dirty   = 1'b0;
    fill_en     = 1'b0;
    unique case (state_q)
      // The ready cycle itself is skipped so a held request isn't replayed.
      IDLE: begin
        if (cpu_req && !cpu_ready_q) begin
          req_addr_d  = cpu_addr[ADDR_W-1:2];
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          first_d     = 1'b1;
          state_d     = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          if (req_we_q) begin
            for (int k = 0; k < WORDS_PER_BLOCK; k++) begin
              wr_mask[k] = (req_woff == k[WOFF_W-1:0]);
            end
            set_dirty = 1'b1;
          end else begin
            cpu_rdata_d = rd_word;
          end
          cpu_ready_d = 1'b1;
          cpu_hit_d   = first_q;
          state_d     = IDLE;
        end else begin
          first_d = 1'b0;
          if (rd_valid && rd_dirty) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {rd_tag, req_idx};
            mem_wdata_d = rd_block;
            state_d     = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_req_q && mem_ack) begin
          clr_dirty = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx};
        end else if (mem_ack) begin
          fill_en   = 1'b1;
          mem_req_d = 1'b0;
          state_d   = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      first_q     <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      cpu_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      first_q     <= first_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_hit   = cpu_hit_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_WB_DM_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (cpu_ready_d && cpu_hit_d && hit_cnt_q != '1)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == COMPARE && !hit && miss_cnt_q != '1)
      miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_q == WRITEBACK && mem_req_q && mem_ack && wb_cnt_q != '1)
      wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_wb_dm.sv
// Bench for cache_wb_dm: directed vectors, reset abort, random ops.
// Reference: flat word memory plus a resident-line directory.
module tb_cache_wb_dm;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata, cpu_rdata;
  logic         cpu_ready, cpu_hit;
  logic         mem_req, mem_we, mem_ack;
  logic [5:0]   mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_WB_DM_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  always #5 clk = ~clk;

  cache_wb_dm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_hit   (cpu_hit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_WB_DM_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .wb_cnt    (wb_cnt)
`endif
  );

  logic [127:0] mem_blocks [64];
  bit   [6:0]   log_q [$];
  bit           auto_mem = 1'b0;
  int           n_cmp = 0;
  int           n_fail = 0;

  task automatic check(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Memory responder: random latency, one-cycle ack, stable-request check.
  initial begin
    logic [134:0] held;
    bit pend;
    int dly;
    mem_ack = 1'b0;
    mem_rdata = '0;
    pend = 1'b0;
    dly = 0;
    held = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (auto_mem && rst_n && mem_req) begin
        if (pend) begin
          check("mem_stable", {mem_we, mem_addr, mem_wdata}, held);
        end else begin
          held = {mem_we, mem_addr, mem_wdata};
          pend = 1'b1;
          dly = $urandom_range(0, 3);
        end
        if (dly == 0) begin
          if (mem_we) mem_blocks[mem_addr] = mem_wdata;
          else mem_rdata = mem_blocks[mem_addr];
          log_q.push_back({mem_we, mem_addr});
          mem_ack = 1'b1;
          pend = 1'b0;
        end else begin
          dly--;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic do_op(input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic hit, output int lat, output int mrc,
                       output logic ok, output logic rdy_after);
    @(posedge clk);
    #1;
    log_q.delete();
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_wdata = wd;
    lat = 0;
    mrc = 0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (mem_req) mrc++;
      if (cpu_ready) ok = 1'b1;
    end
    rd = cpu_rdata;
    hit = cpu_hit;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rdy_after = cpu_ready;
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_hit;
    int          exp_n;
    logic [6:0]  t0;
    logic [6:0]  t1;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  logic [31:0] ref_mem [256];
  logic        m_valid [4];
  logic        m_dirty [4];
  logic [3:0]  m_tag [4];

  initial begin
    logic [31:0] rd;
    logic hit, ok, rdy_after, seen;
    int lat, mrc;

    rst_n = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    for (int i = 0; i < 64; i++)
      mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
    mem_blocks[0] = 128'h11111111_22222222_33333333_44444444;
    mem_blocks[4] = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    mem_blocks[8] = 128'h0;
    mem_blocks[1] = 128'h01010101_02020202_03030303_04040404;

    vecs[0] = '{1'b0, 10'h004, 32'h0, 32'h22222222, 1'b0, 1, 7'h00, 7'h00};
    vecs[1] = '{1'b0, 10'h008, 32'h0, 32'h33333333, 1'b1, 0, 7'h00, 7'h00};
    vecs[2] = '{1'b1, 10'h00C, 32'hDEADBEEF, 32'h0, 1'b1, 0, 7'h00, 7'h00};
    vecs[3] = '{1'b0, 10'h00C, 32'h0, 32'hDEADBEEF, 1'b1, 0, 7'h00, 7'h00};
    vecs[4] = '{1'b0, 10'h04C, 32'h0, 32'hDDDDDDDD, 1'b0, 2, 7'h40, 7'h04};
    vecs[5] = '{1'b1, 10'h084, 32'h12345678, 32'h0, 1'b0, 1, 7'h08, 7'h00};
    vecs[6] = '{1'b0, 10'h084, 32'h0, 32'h12345678, 1'b1, 0, 7'h00, 7'h00};
    vecs[7] = '{1'b0, 10'h014, 32'h0, 32'h02020202, 1'b0, 1, 7'h01, 7'h00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_hit", {cpu_ready, cpu_hit}, 2'b00);
    check("rst_mem_req_we", {mem_req, mem_we}, 2'b00);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_mem_addr_wdata", {mem_addr, mem_wdata}, 134'h0);
    @(negedge clk);
    rst_n = 1'b1;
    auto_mem = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].we, vecs[i].addr, vecs[i].wd, rd, hit, lat, mrc,
            ok, rdy_after);
      check($sformatf("v%0d_done", i), ok, 1'b1);
      check($sformatf("v%0d_hit", i), hit, vecs[i].exp_hit);
      check($sformatf("v%0d_ntxn", i), log_q.size(), vecs[i].exp_n);
      if (vecs[i].exp_n > 0 && log_q.size() > 0)
        check($sformatf("v%0d_txn0", i), log_q[0], vecs[i].t0);
      if (vecs[i].exp_n > 1 && log_q.size() > 1)
        check($sformatf("v%0d_txn1", i), log_q[1], vecs[i].t1);
      if (!vecs[i].we)
        check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      if (vecs[i].exp_hit) begin
        check($sformatf("v%0d_lat", i), lat, 2);
        check($sformatf("v%0d_memreq", i), mrc, 0);
      end
      check($sformatf("v%0d_pulse", i), rdy_after, 1'b0);
`ifdef CACHE_WB_DM_STATS_EN
      if (i == 4) begin
        check("stat_hit", hit_cnt, 32'd3);
        check("stat_miss", miss_cnt, 32'd2);
        check("stat_wb", wb_cnt, 32'd1);
      end
`endif
    end
    check("wb_block0", mem_blocks[0],
          128'h11111111_22222222_33333333_DEADBEEF);

    // Abort a fill with reset; set 2 is empty so the miss goes to fill.
    auto_mem = 1'b0;
    @(posedge clk);
    #1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 10'h028;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mem_req) seen = 1'b1;
    end
    check("abort_req_seen", seen, 1'b1);
    check("abort_fill_cmd", {mem_we, mem_addr}, 7'h02);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_req_drop", mem_req, 1'b0);
    check("abort_ready", cpu_ready, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    auto_mem = 1'b1;

    do_op(1'b0, 10'h004, 32'h0, rd, hit, lat, mrc, ok, rdy_after);
    check("post_rst_hit", hit, 1'b0);
    check("post_rst_txn", log_q.size() > 0 ? log_q[0] : 7'h7F, 7'h00);
    check("post_rst_rdata", rd, 32'h22222222);
    do_op(1'b0, 10'h084, 32'h0, rd, hit, lat, mrc, ok, rdy_after);
    check("dirty_lost_ntxn", log_q.size(), 1);
    check("dirty_lost_rdata", rd, 32'h0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 0; w < 256; w++)
      ref_mem[w] = mem_blocks[w >> 2][127 - 32 * (w % 4) -: 32];
    for (int s = 0; s < 4; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
      m_tag[s] = '0;
    end

    for (int n = 0; n < 300; n++) begin
      int tg, ix, wo;
      logic [9:0] a;
      logic we, ehit, ewb;
      logic [31:0] wd;
      tg = $urandom_range(0, 3);
      ix = $urandom_range(0, 3);
      wo = $urandom_range(0, 3);
      a = {tg[3:0], ix[1:0], wo[1:0], 2'b00};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      ehit = m_valid[ix] && m_tag[ix] == tg[3:0];
      ewb = !ehit && m_valid[ix] && m_dirty[ix];
      do_op(we, a, wd, rd, hit, lat, mrc, ok, rdy_after);
      check($sformatf("r%0d_done", n), ok, 1'b1);
      check($sformatf("r%0d_hit", n), hit, ehit);
      check($sformatf("r%0d_ntxn", n), log_q.size(),
            ehit ? 0 : (ewb ? 2 : 1));
      if (ewb && log_q.size() > 0)
        check($sformatf("r%0d_wbaddr", n), log_q[0],
              {1'b1, m_tag[ix], ix[1:0]});
      if (!we)
        check($sformatf("r%0d_rdata", n), rd, ref_mem[a[9:2]]);
      if (ehit)
        check($sformatf("r%0d_lat", n), lat, 2);
      if (!ehit) begin
        m_valid[ix] = 1'b1;
        m_tag[ix] = tg[3:0];
        m_dirty[ix] = 1'b0;
      end
      if (we) begin
        ref_mem[a[9:2]] = wd;
        m_dirty[ix] = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
